// File: rtl/teeter_game_ctrl_if.sv
// teeter_game_ctrl_if: frame/button/ball-position inputs and game status outputs of the level sequencer
interface teeter_game_ctrl_if;
  logic        screenend;
  logic        btn_start;
  logic        btn_pause;
  logic [9:0]  bl_x;
  logic [9:0]  bl_y;
  logic        is_game_playing;
  logic        ball_rst;
  logic [9:0]  init_x;
  logic [9:0]  init_y;
  logic [1:0]  level;
  logic [2:0]  lives;
  logic [15:0] frame_cnt;
  logic        game_over;
  logic        game_won;
  modport master (
    output screenend, btn_start, btn_pause, bl_x, bl_y,
    input  is_game_playing, ball_rst, init_x, init_y, level, lives, frame_cnt, game_over, game_won
  );
  modport slave (
    input  screenend, btn_start, btn_pause, bl_x, bl_y,
    output is_game_playing, ball_rst, init_x, init_y, level, lives, frame_cnt, game_over, game_won
  );
endinterface

// File: rtl/teeter_game_ctrl.sv
// teeter_game_ctrl: level/round sequencer that gates the ball mover and judges hole/goal hits once per frame
module teeter_game_ctrl #(
  parameter int          SPRITE_SIZE   = 32,
  parameter int          NUM_LEVELS    = 4,
  parameter int          LIVES         = 3,
  parameter int          SETTLE_FRAMES = 30,
  parameter int          FALL_FRAMES   = 60,
  parameter int          CLEAR_FRAMES  = 90,
  parameter int          HOLE_R        = 8,
  parameter int          GOAL_R        = 10,
  parameter logic [39:0] LVL_START_X   = {10'd160, 10'd140, 10'd120, 10'd100},
  parameter logic [39:0] LVL_START_Y   = {10'd80, 10'd70, 10'd60, 10'd50},
  parameter logic [39:0] LVL_HOLE_X    = {10'd260, 10'd240, 10'd220, 10'd200},
  parameter logic [39:0] LVL_HOLE_Y    = {10'd130, 10'd120, 10'd110, 10'd100},
  parameter logic [39:0] LVL_GOAL_X    = {10'd340, 10'd320, 10'd300, 10'd280},
  parameter logic [39:0] LVL_GOAL_Y    = {10'd170, 10'd160, 10'd150, 10'd140}
) (
  input logic CLK,
  input logic rst,
  teeter_game_ctrl_if.slave io
);
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_LOAD     = 4'd1;
  localparam logic [3:0] S_SETTLE   = 4'd2;
  localparam logic [3:0] S_PLAY     = 4'd3;
  localparam logic [3:0] S_PAUSE    = 4'd4;
  localparam logic [3:0] S_FALL     = 4'd5;
  localparam logic [3:0] S_CLEAR    = 4'd6;
  localparam logic [3:0] S_GAMEOVER = 4'd7;
  localparam logic [3:0] S_WIN      = 4'd8;
  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
  logic [3:0]  state;
  logic [1:0]  level;
  logic [2:0]  lives;
  logic [15:0] frame_cnt;
  logic [15:0] fcnt;
  logic [15:0] fcnt_last;
  logic        fcnt_done;
  logic        hole_hit;
  logic        goal_hit;
  function automatic logic near(input logic [9:0] p, input logic [9:0] t, input int r);
    logic [10:0]        c;
    logic signed [11:0] d;
    logic [11:0]        a;
    c = {1'b0, p} + 11'(SPRITE_SIZE / 2);
    d = $signed({1'b0, c}) - $signed({2'b00, t});
    a = d[11] ? 12'(-d) : 12'(d);
    return a <= 12'(r);
  endfunction
  assign hole_hit = near(io.bl_x, LVL_HOLE_X[10*level +: 10], HOLE_R) && near(io.bl_y, LVL_HOLE_Y[10*level +: 10], HOLE_R);
  assign goal_hit = near(io.bl_x, LVL_GOAL_X[10*level +: 10], GOAL_R) && near(io.bl_y, LVL_GOAL_Y[10*level +: 10], GOAL_R);
  assign fcnt_last = state == S_SETTLE ? 16'(SETTLE_FRAMES - 1) :
                     state == S_FALL   ? 16'(FALL_FRAMES - 1)   : 16'(CLEAR_FRAMES - 1);
  assign fcnt_done = io.screenend && fcnt == fcnt_last;
  // game sequencing: load/settle/play/pause/fall/clear plus lives, level and play-time bookkeeping
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= S_IDLE;
      level     <= 2'd0;
      lives     <= 3'(LIVES);
      frame_cnt <= 16'd0;
      fcnt      <= 16'd0;
    end else begin
      case (state)
        S_IDLE, S_GAMEOVER, S_WIN: if (io.btn_start) begin
          state     <= S_LOAD;
          level     <= 2'd0;
          lives     <= 3'(LIVES);
          frame_cnt <= 16'd0;
        end
        S_LOAD: begin
          state <= S_SETTLE;
          fcnt  <= 16'd0;
        end
        S_SETTLE, S_FALL, S_CLEAR: if (fcnt_done) begin
          state <= state == S_SETTLE ? S_PLAY :
                   state == S_FALL   ? (lives != 3'd0 ? S_LOAD : S_GAMEOVER) :
                   (level == LAST_LEVEL ? S_WIN : S_LOAD);
          if (state == S_CLEAR && level != LAST_LEVEL) level <= level + 2'd1;
        end else if (io.screenend) begin
          fcnt <= fcnt + 16'd1;
        end
        S_PLAY: begin
          fcnt <= 16'd0;
          if (io.screenend && frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 16'd1;
          if (io.screenend && hole_hit) begin
            state <= S_FALL;
            lives <= lives - 3'd1;
          end else if (io.screenend && goal_hit) begin
            state <= S_CLEAR;
          end else if (io.btn_pause) begin
            state <= S_PAUSE;
          end
        end
        S_PAUSE: if (io.btn_pause) state <= S_PLAY;
        default: state <= S_IDLE;
      endcase
    end
  end
  assign io.is_game_playing = state == S_PLAY;
  assign io.ball_rst        = state == S_LOAD;
  assign io.game_over       = state == S_GAMEOVER;
  assign io.game_won        = state == S_WIN;
  assign io.init_x          = LVL_START_X[10*level +: 10];
  assign io.init_y          = LVL_START_Y[10*level +: 10];
  assign io.level           = level;
  assign io.lives           = lives;
  assign io.frame_cnt       = frame_cnt;
endmodule

// File: tb/tb_teeter_game_ctrl.sv
// tb_teeter_game_ctrl: table-driven and sequence checks of the game sequencer against a scoreboard model
module tb_teeter_game_ctrl;
  localparam logic [39:0] SX = {10'd160, 10'd140, 10'd120, 10'd100};
  localparam logic [39:0] SY = {10'd80, 10'd70, 10'd60, 10'd50};
  localparam logic [39:0] HX = {10'd260, 10'd240, 10'd220, 10'd200};
  localparam logic [39:0] HY = {10'd130, 10'd120, 10'd110, 10'd100};
  localparam logic [39:0] GX = {10'd340, 10'd320, 10'd300, 10'd280};
  localparam logic [39:0] GY = {10'd170, 10'd160, 10'd150, 10'd140};
  int sx[4] = '{100, 120, 140, 160};
  int sy[4] = '{50, 60, 70, 80};
  int gx[4] = '{280, 300, 320, 340};
  int gy[4] = '{140, 150, 160, 170};
  logic CLK = 1'b0;
  logic rst = 1'b1;
  logic se = 1'b0, bs = 1'b0, bp = 1'b0;
  logic [9:0] bx = 10'd0, by = 10'd0;
  always #5 CLK = ~CLK;
  teeter_game_ctrl_if ifa ();
  teeter_game_ctrl_if ifb ();
  assign ifa.screenend = se;
  assign ifa.btn_start = bs;
  assign ifa.btn_pause = bp;
  assign ifa.bl_x      = bx;
  assign ifa.bl_y      = by;
  assign ifb.screenend = se;
  assign ifb.btn_start = bs;
  assign ifb.btn_pause = bp;
  assign ifb.bl_x      = bx;
  assign ifb.bl_y      = by;
  teeter_game_ctrl #(
    .LVL_START_X(SX), .LVL_START_Y(SY), .LVL_HOLE_X(HX), .LVL_HOLE_Y(HY), .LVL_GOAL_X(GX), .LVL_GOAL_Y(GY)
  ) dut (.CLK(CLK), .rst(rst), .io(ifa));
  // second instance: goal box placed exactly over the hole box
  teeter_game_ctrl #(
    .GOAL_R(8), .LVL_START_X(SX), .LVL_START_Y(SY), .LVL_HOLE_X(HX), .LVL_HOLE_Y(HY), .LVL_GOAL_X(HX), .LVL_GOAL_Y(HY)
  ) dut2 (.CLK(CLK), .rst(rst), .io(ifb));
  typedef struct {
    string       name;
    logic        igp, brst, go, gw;
    logic [1:0]  lvl;
    logic [2:0]  lv;
    logic [15:0] fc;
    logic [9:0]  ix, iy;
  } exp_t;
  typedef struct {
    int    x, y;
    int    fall;
    bit    chk2;
    string nm;
  } vec_t;
  exp_t sb[$];
  vec_t tbl[6];
  int n_chk = 0, n_pass = 0;
  int m_level = 0, m_lives = 3, m_fc = 0;
  bit m_play = 1'b0;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic push(input string nm, input logic igp, input logic brst, input logic go, input logic gw);
    exp_t e;
    e.name = nm; e.igp = igp; e.brst = brst; e.go = go; e.gw = gw;
    e.lvl = 2'(m_level); e.lv = 3'(m_lives); e.fc = 16'(m_fc);
    e.ix = 10'(sx[m_level]); e.iy = 10'(sy[m_level]);
    sb.push_back(e);
  endtask
  task automatic sample();
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    if ({ifa.is_game_playing, ifa.ball_rst, ifa.game_over, ifa.game_won, ifa.level, ifa.lives, ifa.frame_cnt, ifa.init_x, ifa.init_y}
        === {e.igp, e.brst, e.go, e.gw, e.lvl, e.lv, e.fc, e.ix, e.iy}) n_pass++;
    else $display("FAIL %s: got igp=%b brst=%b go=%b gw=%b lvl=%0d lives=%0d fc=%0d init=(%0d,%0d) want igp=%b brst=%b go=%b gw=%b lvl=%0d lives=%0d fc=%0d init=(%0d,%0d)",
                  e.name, ifa.is_game_playing, ifa.ball_rst, ifa.game_over, ifa.game_won, ifa.level, ifa.lives, ifa.frame_cnt,
                  ifa.init_x, ifa.init_y, e.igp, e.brst, e.go, e.gw, e.lvl, e.lv, e.fc, e.ix, e.iy);
  endtask
  task automatic expect_out(input string nm, input logic igp, input logic brst, input logic go, input logic gw);
    push(nm, igp, brst, go, gw);
    sample();
  endtask
  task automatic frame();
    se = 1'b1;
    tick();
    se = 1'b0;
    if (m_play) m_fc++;
    tick();
  endtask
  task automatic load_seq(input string nm);
    expect_out({nm, "_load"}, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    expect_out({nm, "_settle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (29) frame();
    expect_out({nm, "_presettle"}, 1'b0, 1'b0, 1'b0, 1'b0);
    frame();
    m_play = 1'b1;
    expect_out({nm, "_play"}, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic start_game(input string nm);
    bs = 1'b1;
    tick();
    bs = 1'b0;
    m_level = 0; m_lives = 3; m_fc = 0; m_play = 1'b0;
    load_seq(nm);
  endtask
  task automatic last_frame_load(input string nm);
    se = 1'b1;
    tick();
    se = 1'b0;
    load_seq(nm);
  endtask
  task automatic fall_recover(input string nm);
    repeat (59) frame();
    expect_out({nm, "_fallhold"}, 1'b0, 1'b0, 1'b0, 1'b0);
    if (m_lives != 0) last_frame_load(nm);
    else begin
      se = 1'b1;
      tick();
      se = 1'b0;
      expect_out({nm, "_gameover"}, 1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask
  task automatic hit_frame(input int x, input int y);
    bx = 10'(x);
    by = 10'(y);
    frame();
    bx = 10'd0;
    by = 10'd0;
  endtask
  task automatic clear_level(input int x, input int y, input string nm);
    hit_frame(x, y);
    m_play = 1'b0;
    expect_out({nm, "_clear"}, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (89) frame();
    expect_out({nm, "_clearhold"}, 1'b0, 1'b0, 1'b0, 1'b0);
    if (m_level == 3) begin
      se = 1'b1;
      tick();
      se = 1'b0;
      expect_out({nm, "_win"}, 1'b0, 1'b0, 1'b0, 1'b1);
    end else begin
      m_level++;
      last_frame_load(nm);
    end
  endtask
  initial begin
    tbl[0] = '{193, 84, 0, 1'b0, "miss_dx9"};
    tbl[1] = '{184, 93, 0, 1'b0, "miss_dy9"};
    tbl[2] = '{175, 84, 0, 1'b0, "miss_dxm9"};
    tbl[3] = '{184, 84, 1, 1'b1, "hole_centre"};
    tbl[4] = '{192, 92, 1, 1'b0, "hole_edge_p8"};
    tbl[5] = '{176, 76, 1, 1'b0, "hole_edge_m8"};
    tick();
    tick();
    rst = 1'b0;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    start_game("start");
    for (int i = 0; i < 6; i++) begin
      hit_frame(tbl[i].x, tbl[i].y);
      if (tbl[i].fall != 0) begin
        m_play = 1'b0;
        m_lives--;
        expect_out(tbl[i].nm, 1'b0, 1'b0, 1'b0, 1'b0);
        if (tbl[i].chk2) begin
          n_chk++;
          if (ifb.lives === 3'd2 && ifb.is_game_playing === 1'b0) n_pass++;
          else $display("FAIL overlap_hole_wins: got lives=%0d igp=%b want lives=2 igp=0", ifb.lives, ifb.is_game_playing);
        end
        fall_recover(tbl[i].nm);
      end else begin
        expect_out(tbl[i].nm, 1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
    start_game("restart");
    hit_frame(275, 124);
    expect_out("goal_miss_dx11", 1'b1, 1'b0, 1'b0, 1'b0);
    clear_level(274, 134, "goal_edge10");
    clear_level(gx[1] - 16, gy[1] - 16, "lvl1");
    clear_level(gx[2] - 16, gy[2] - 16, "lvl2");
    clear_level(gx[3] - 16, gy[3] - 16, "lvl3");
    start_game("pause");
    bp = 1'b1;
    tick();
    bp = 1'b0;
    m_play = 1'b0;
    expect_out("pause_on", 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) frame();
    expect_out("pause_frozen", 1'b0, 1'b0, 1'b0, 1'b0);
    bs = 1'b1;
    tick();
    bs = 1'b0;
    expect_out("pause_start_ignored", 1'b0, 1'b0, 1'b0, 1'b0);
    bp = 1'b1;
    tick();
    bp = 1'b0;
    m_play = 1'b1;
    expect_out("pause_off", 1'b1, 1'b0, 1'b0, 1'b0);
    frame();
    expect_out("play_counts", 1'b1, 1'b0, 1'b0, 1'b0);
    bx = 10'd184;
    by = 10'd84;
    bp = 1'b1;
    se = 1'b1;
    tick();
    se = 1'b0;
    bp = 1'b0;
    m_fc++;
    m_play = 1'b0;
    m_lives--;
    tick();
    bx = 10'd0;
    by = 10'd0;
    expect_out("pause_vs_hole", 1'b0, 1'b0, 1'b0, 1'b0);
    fall_recover("pvh");
    clear_level(gx[0] - 16, gy[0] - 16, "r0");
    clear_level(gx[1] - 16, gy[1] - 16, "r1");
    frame();
    expect_out("lvl2_play", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_level = 0; m_lives = 3; m_fc = 0; m_play = 1'b0;
    expect_out("rst_midplay", 1'b0, 1'b0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
